// File: rtl/hdmi_pcie_burst_reader.sv
// ----------------------------------------------------------------------------
// hdmi_pcie_burst_reader
//   Read-side consumer of the HDMI->PCIe prefetch FIFO. Pops DATA_WIDTH-bit
//   words in fixed BURST_LEN bursts, requests a DMA slot for every burst and
//   streams the words to the PCIe DMA engine through a registered valid/ready
//   stage. Tracks the burst index within a frame, advances the burst byte
//   address and pulses frame_done once the final burst of a frame is accepted.
//
// Ports
//   rd_clk, rd_rst            clock, asynchronous active-high reset
//   cap_en                    capture enable (level)
//   frame_start, frame_base   frame start pulse and frame base byte address
//   fifo_rd_en/vld/data       prefetch FIFO pop interface (show-ahead)
//   dma_req/ack/addr          per-burst DMA slot handshake and burst address
//   m_valid/ready/data/last   registered output stream
//   frame_done                1-cycle pulse at end of a complete frame
//   busy                      FSM is not idle
// ----------------------------------------------------------------------------
module hdmi_pcie_burst_reader #(
    parameter int DATA_WIDTH  = 128,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 115200,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  cap_en,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] frame_base,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  dma_req,
    input  logic                  dma_ack,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int NUM_BURSTS  = FRAME_WORDS / BURST_LEN;
    localparam int IDX_W       = $clog2(NUM_BURSTS + 1);
    localparam int CNT_W       = $clog2(BURST_LEN + 1);
    localparam int BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_NEXT = 2'd3;

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_BURSTS - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_BYTES);

    logic [1:0]            state_r;
    logic [IDX_W-1:0]      burst_idx_r;
    logic [CNT_W-1:0]      issued_r;
    logic [CNT_W-1:0]      accepted_r;
    logic                  dma_req_r;
    logic [ADDR_WIDTH-1:0] dma_addr_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic                  frame_done_r;
    logic                  pop_s;
    logic                  accept_s;

    // Pop only in XFER, only a valid head word, never beyond the burst length,
    // and only when the output register is empty or being drained this cycle.
    always_comb begin
        pop_s = 1'b0;
        if (state_r == ST_XFER) begin
            pop_s = fifo_rd_vld & (issued_r < CNT_FULL) & (~m_valid_r | m_ready);
        end else begin
            pop_s = 1'b0;
        end
    end

    assign accept_s = m_valid_r & m_ready;

    // Burst sequencing FSM: DMA slot request, per-burst counters, frame progress.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_r      <= ST_IDLE;
            burst_idx_r  <= '0;
            issued_r     <= '0;
            accepted_r   <= '0;
            dma_req_r    <= 1'b0;
            dma_addr_r   <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (frame_start && cap_en) begin
                        state_r     <= ST_REQ;
                        dma_req_r   <= 1'b1;
                        dma_addr_r  <= frame_base;
                        burst_idx_r <= '0;
                    end
                end
                ST_REQ: begin
                    if (dma_ack) begin
                        state_r    <= ST_XFER;
                        dma_req_r  <= 1'b0;
                        issued_r   <= '0;
                        accepted_r <= '0;
                    end
                end
                ST_XFER: begin
                    if (pop_s) begin
                        issued_r <= issued_r + CNT_ONE;
                    end
                    if (accept_s) begin
                        accepted_r <= accepted_r + CNT_ONE;
                        // m_last only ever marks the final beat of this burst
                        if (m_last_r) begin
                            state_r <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    burst_idx_r <= burst_idx_r + IDX_ONE;
                    if (burst_idx_r == LAST_IDX) begin
                        frame_done_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else if (!cap_en) begin
                        // capture stopped: abort quietly at the burst boundary
                        state_r <= ST_IDLE;
                    end else begin
                        state_r    <= ST_REQ;
                        dma_req_r  <= 1'b1;
                        // running address wraps modulo 2^ADDR_WIDTH
                        dma_addr_r <= dma_addr_r + ADDR_STEP;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    dma_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered output stage: load on pop, clear on an accept without refill.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
        end else if (pop_s) begin
            m_data_r  <= fifo_rd_data;
            m_valid_r <= 1'b1;
            m_last_r  <= (issued_r == CNT_LAST);
        end else if (accept_s) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end
    end

    assign fifo_rd_en = pop_s;
    assign dma_req    = dma_req_r;
    assign dma_addr   = dma_addr_r;
    assign m_valid    = m_valid_r;
    assign m_last     = m_last_r;
    assign m_data     = m_data_r;
    assign frame_done = frame_done_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_hdmi_pcie_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_hdmi_pcie_burst_reader
//   Directed bench for hdmi_pcie_burst_reader with a short frame (8 bursts of
//   16 words). A FIFO model supplies numbered words, a DMA model grants each
//   request after three cycles, and a per-cycle monitor checks stream order,
//   m_last placement, stall stability, pop legality and burst addresses.
// ----------------------------------------------------------------------------
module tb_hdmi_pcie_burst_reader;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int BL = 16;
    localparam int FW = 128;
    localparam int NB = FW / BL;

    logic          clk;
    logic          rd_rst;
    logic          cap_en;
    logic          frame_start;
    logic [AW-1:0] frame_base;
    logic          fifo_rd_en;
    logic          fifo_rd_vld;
    logic [DW-1:0] fifo_rd_data;
    logic          dma_req;
    logic          dma_ack;
    logic [AW-1:0] dma_addr;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          frame_done;
    logic          busy;

    hdmi_pcie_burst_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .FRAME_WORDS(FW),
        .ADDR_WIDTH (AW)
    ) dut (
        .rd_clk      (clk),
        .rd_rst      (rd_rst),
        .cap_en      (cap_en),
        .frame_start (frame_start),
        .frame_base  (frame_base),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_vld (fifo_rd_vld),
        .fifo_rd_data(fifo_rd_data),
        .dma_req     (dma_req),
        .dma_ack     (dma_ack),
        .dma_addr    (dma_addr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned head;
    int unsigned exp_beat;
    int unsigned beat0;
    int          beat_in_burst;
    int          pops_in_burst;
    int          req_cnt;
    int          bursts;
    int          fd_cnt;
    int          fd0;
    int          vld_pct;
    int          rdy_pct;
    logic [31:0] exp_addr;
    logic [31:0] addr_log [0:15];
    logic        stall_prev;
    logic [DW-1:0] prev_data;
    logic        fs_pending;
    logic        pop;
    logic        ack_next;

    // Distinct, non-trivial payload for FIFO word number i.
    function automatic logic [DW-1:0] word(input int unsigned i);
        logic [31:0] v;
        v = i;
        return {v ^ 32'hDEAD_0000, ~v, v + 32'h1234_5678, v};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at negedge, then drive the models just after posedge.
    task automatic cycle();
        @(negedge clk);
        if (fifo_rd_en) begin
            check("rd_en_needs_vld", fifo_rd_vld, 1'b1);
            check("no_pop_in_req", dma_req, 1'b0);
            check("pops_per_burst", (pops_in_burst < BL), 1'b1);
            pops_in_burst++;
        end
        if (stall_prev) begin
            check("stall_valid", m_valid, 1'b1);
            check("stall_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
            check("m_data", m_data, word(exp_beat));
            check("m_last", m_last, (beat_in_burst == BL - 1));
            exp_beat++;
            beat_in_burst = (beat_in_burst == BL - 1) ? 0 : beat_in_burst + 1;
        end
        if (dma_req) begin
            if (req_cnt == 0) begin
                check("dma_addr", dma_addr, exp_addr);
                if (bursts < 16) addr_log[bursts] = dma_addr;
                exp_addr      = exp_addr + 32'h0000_0100;
                bursts++;
                pops_in_burst = 0;
            end
            req_cnt++;
        end else begin
            req_cnt = 0;
        end
        if (frame_done) fd_cnt++;
        pop        = fifo_rd_en;
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        ack_next   = dma_req && (req_cnt == 3);
        @(posedge clk);
        #1;
        if (pop) head++;
        fifo_rd_data = word(head);
        dma_ack      = ack_next;
        frame_start  = fs_pending;
        fs_pending   = 1'b0;
        fifo_rd_vld  = ($urandom_range(0, 99) < vld_pct);
        m_ready      = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic start_frame(input logic [31:0] base);
        frame_base = base;
        exp_addr   = base;
        bursts     = 0;
        beat0      = exp_beat;
        fd0        = fd_cnt;
        fs_pending = 1'b1;
        cycle();
        cycle();
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_frame(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            cycle();
            n++;
        end
        check({tag, "_budget"}, (n < 5000), 1'b1);
        repeat (3) cycle();
    endtask

    task automatic resync();
        exp_beat      = head;
        beat_in_burst = 0;
        pops_in_burst = 0;
        req_cnt       = 0;
        stall_prev    = 1'b0;
    endtask

    initial begin
        int n;
        rd_rst = 1'b1; cap_en = 1'b0; frame_start = 1'b0; frame_base = 32'h0;
        fifo_rd_vld = 1'b0; dma_ack = 1'b0; m_ready = 1'b0;
        head = 0; exp_beat = 0; beat0 = 0; fd_cnt = 0; fd0 = 0; bursts = 0;
        exp_addr = 32'h0; fs_pending = 1'b0; vld_pct = 100; rdy_pct = 100;
        fifo_rd_data = word(0);
        resync();

        // Reset state
        #3;
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_dma_req", dma_req, 1'b0);
        check("rst_dma_addr", dma_addr, 32'h0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rd_rst = 1'b0;
        cap_en = 1'b1;
        repeat (2) cycle();

        // 1: full-rate frame
        start_frame(32'h1000_0000);
        run_frame("t1");
        check("t1_bursts", bursts, NB);
        check("t1_beats", exp_beat - beat0, FW);
        check("t1_frame_done", fd_cnt - fd0, 1);
        check("t1_addr1", addr_log[1], 32'h1000_0100);
        check("t1_addr7", addr_log[7], 32'h1000_0700);

        // 2: random FIFO valid and sink ready
        vld_pct = 70; rdy_pct = 50;
        start_frame(32'h2000_0000);
        run_frame("t2");
        check("t2_bursts", bursts, NB);
        check("t2_beats", exp_beat - beat0, FW);
        check("t2_no_loss", exp_beat, head);
        check("t2_frame_done", fd_cnt - fd0, 1);
        vld_pct = 100; rdy_pct = 100;

        // 3: drop cap_en during the 5th burst
        start_frame(32'h3000_0000);
        n = 0;
        while (!(bursts == 5 && beat_in_burst == 3) && n < 2000) begin
            cycle();
            n++;
        end
        check("t3_reach", (n < 2000), 1'b1);
        cap_en = 1'b0;
        run_frame("t3");
        repeat (20) cycle();
        check("t3_bursts", bursts, 5);
        check("t3_beats", exp_beat - beat0, 5 * BL);
        check("t3_no_frame_done", fd_cnt - fd0, 0);
        check("t3_addr4", addr_log[4], 32'h3000_0400);
        check("t3_idle", busy, 1'b0);
        cap_en = 1'b1;
        start_frame(32'h3100_0000);
        run_frame("t3r");
        check("t3r_addr0", addr_log[0], 32'h3100_0000);
        check("t3r_bursts", bursts, NB);
        check("t3r_frame_done", fd_cnt - fd0, 1);

        // 4: address wrap and frame_start while busy
        start_frame(32'hFFFF_FF80);
        n = 0;
        while (bursts < 2 && n < 2000) begin
            cycle();
            n++;
        end
        check("t4_reach", (n < 2000), 1'b1);
        frame_base = 32'h5555_0000;
        fs_pending = 1'b1;
        run_frame("t4");
        repeat (10) cycle();
        check("t4_wrap_addr", addr_log[1], 32'h0000_0080);
        check("t4_bursts", bursts, NB);
        check("t4_frame_done", fd_cnt - fd0, 1);
        check("t4_no_restart", busy, 1'b0);

        // 5: asynchronous reset at beat 7 of a burst
        start_frame(32'h4000_0000);
        n = 0;
        while (!(bursts == 2 && beat_in_burst == 7) && n < 2000) begin
            cycle();
            n++;
        end
        check("t5_reach", (n < 2000), 1'b1);
        #2;
        rd_rst = 1'b1;
        #1;
        check("t5_rd_en", fifo_rd_en, 1'b0);
        check("t5_dma_req", dma_req, 1'b0);
        check("t5_dma_addr", dma_addr, 32'h0);
        check("t5_m_valid", m_valid, 1'b0);
        check("t5_m_last", m_last, 1'b0);
        check("t5_m_data", m_data, '0);
        check("t5_busy", busy, 1'b0);
        check("t5_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rd_rst  = 1'b0;
        dma_ack = 1'b0;
        resync();
        repeat (2) cycle();
        start_frame(32'h4800_0000);
        run_frame("t5r");
        check("t5r_addr0", addr_log[0], 32'h4800_0000);
        check("t5r_bursts", bursts, NB);
        check("t5r_beats", exp_beat - beat0, FW);
        check("t5r_frame_done", fd_cnt - fd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
